// File: rtl/rv_arb_pkg.sv
// Shared constants and helpers for the round-robin stream arbiter.
package rv_arb_pkg;

  // Largest supported number of requesting streams.
  localparam int RV_ARB_MAX_INPUTS = 32;

  // $clog2 with a floor of 1 so a single-input build still gets a 1-bit index.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/RV_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requester strictly above the last
// accepted index, wrapping around. With LOCK_ENABLE the pointer only moves
// when the caller confirms acceptance through enable.
module RV_rr_arbiter import rv_arb_pkg::*; #(
  parameter int NUM_REQS     = 4,
  parameter int LOCK_ENABLE  = 1,
  parameter int LOG_NUM_REQS = clog2_min1(NUM_REQS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQS-1:0]     requests,
  input  logic                    enable,
  output logic [NUM_REQS-1:0]     grant_onehot,
  output logic [LOG_NUM_REQS-1:0] grant_index
);

  logic [LOG_NUM_REQS-1:0] ptr_q, ptr_d;
  logic                    grant_valid;

  // Scan from the pointer's successor; walking downward lets the nearest
  // requester overwrite farther ones, so no early exit is needed.
  always_comb begin
    int                      idx;
    logic [LOG_NUM_REQS-1:0] sel;
    grant_onehot = '0;
    grant_index  = '0;
    grant_valid  = 1'b0;
    idx          = 0;
    sel          = '0;
    for (int i = NUM_REQS; i >= 1; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQS) idx = idx - NUM_REQS;
      sel = LOG_NUM_REQS'(idx);
      if (requests[sel]) begin
        grant_onehot      = '0;
        grant_onehot[sel] = 1'b1;
        grant_index       = sel;
        grant_valid       = 1'b1;
      end
    end
  end

  // Pointer advances to the winner only once the grant is actually taken.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_valid && (LOCK_ENABLE == 0 || enable)) ptr_d = grant_index;
  end

  // Reset the pointer to the top index so input 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= LOG_NUM_REQS'(NUM_REQS - 1);
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rv_stream_arbiter.sv
// N-to-1 valid/ready stream arbiter with round-robin fairness and a
// registered output stage tagged with the source index.
// Optional packet lock: define RV_STREAM_ARB_PKT_LOCK_EN to hold the grant
// on one input from its first beat until the beat carrying last_in.
module rv_stream_arbiter import rv_arb_pkg::*; #(
  parameter int NUM_INPUTS     = 4,
  parameter int DATAW          = 32,
  parameter int LOG_NUM_INPUTS = clog2_min1(NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS-1:0]       valid_in,
  input  logic [NUM_INPUTS*DATAW-1:0] data_in,
  input  logic [NUM_INPUTS-1:0]       last_in,
  output logic [NUM_INPUTS-1:0]       ready_in,
  output logic                        valid_out,
  output logic [DATAW-1:0]            data_out,
  output logic [LOG_NUM_INPUTS-1:0]   sel_out,
  output logic                        last_out,
  input  logic                        ready_out
);

  logic                      stage_ready, fire_in, arb_en;
  logic [NUM_INPUTS-1:0]     arb_req, grant_onehot;
  logic [LOG_NUM_INPUTS-1:0] grant_index;

  logic                      valid_q, valid_d;
  logic [DATAW-1:0]          data_q, data_d;
  logic [LOG_NUM_INPUTS-1:0] sel_q, sel_d;
  logic                      last_q, last_d;

  assign stage_ready = !valid_q || ready_out;
  assign ready_in    = grant_onehot & {NUM_INPUTS{stage_ready}};
  assign fire_in     = |(valid_in & ready_in);

`ifdef RV_STREAM_ARB_PKT_LOCK_EN
  logic                      lock_q, lock_d;
  logic [LOG_NUM_INPUTS-1:0] lock_idx_q, lock_idx_d;

  // While locked, hide every other requester so only the owner can be granted.
  always_comb begin
    arb_req = valid_in;
    if (lock_q) begin
      arb_req              = '0;
      arb_req[lock_idx_q]  = valid_in[lock_idx_q];
    end
  end

  // Fairness pointer moves only when a packet completes.
  assign arb_en = fire_in && last_in[grant_index];

  // Each accepted beat either opens/keeps the lock or releases it on last.
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (fire_in) begin
      lock_d     = !last_in[grant_index];
      lock_idx_d = grant_index;
    end
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`else
  assign arb_req = valid_in;
  assign arb_en  = fire_in;
`endif

  RV_rr_arbiter #(
    .NUM_REQS     (NUM_INPUTS),
    .LOCK_ENABLE  (1),
    .LOG_NUM_REQS (LOG_NUM_INPUTS)
  ) u_rr (
    .clk          (clk),
    .reset        (reset),
    .requests     (arb_req),
    .enable       (arb_en),
    .grant_onehot (grant_onehot),
    .grant_index  (grant_index)
  );

  // Output stage: load the winner on fire, drop valid once drained, else hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (fire_in) begin
      valid_d = 1'b1;
      data_d  = data_in[int'(grant_index)*DATAW +: DATAW];
      sel_d   = grant_index;
      last_d  = last_in[grant_index];
    end else if (ready_out) begin
      valid_d = 1'b0;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign sel_out   = sel_q;
  assign last_out  = last_q;

endmodule

// File: tb/tb_rv_stream_arbiter.sv
// Bench for rv_stream_arbiter: table of cycle vectors with fixed expected
// outputs, plus a reference model feeding a scoreboard of accepted words.
module tb_rv_stream_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    valid_in, last_in, ready_in;
  logic [N*DW-1:0] data_in;
  logic            valid_out, last_out, ready_out;
  logic [DW-1:0]   data_out;
  logic [LW-1:0]   sel_out;

  rv_stream_arbiter #(.NUM_INPUTS(N), .DATAW(DW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .last_in(last_in), .ready_in(ready_in), .valid_out(valid_out),
    .data_out(data_out), .sel_out(sel_out), .last_out(last_out),
    .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [LW-1:0] sel;
    logic          last;
  } beat_t;

  typedef struct {
    logic [N-1:0] vin;
    logic [N-1:0] lin;
    logic         rdy;
    logic         exp_v;
    int           exp_sel;
  } vec_t;

  beat_t sbq[$];
  vec_t  vecs[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    m_ptr, m_lidx;
  bit    m_vout, m_lock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [N-1:0] vin, input logic rdy, input logic ev, input int es);
    vec_t v;
    v.vin = vin; v.lin = 4'hF; v.rdy = rdy; v.exp_v = ev; v.exp_sel = es;
    return v;
  endfunction

  // Reference model evaluated just before each clock edge.
  task automatic model_step();
    int           g;
    bit           sr;
    beat_t        b;
    logic [N-1:0] exp_rdy;
    if (reset) begin
      m_ptr = N - 1; m_vout = 0; m_lock = 0; m_lidx = 0;
      sbq.delete();
      return;
    end
    sr = !m_vout || ready_out;
    g  = -1;
    if (m_lock) begin
      if (valid_in[m_lidx]) g = m_lidx;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && valid_in[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0 && sr) exp_rdy[g] = 1'b1;
    chk("valid_out", 64'(valid_out), 64'(m_vout));
    chk("ready_in", 64'(ready_in), 64'(exp_rdy));
    if (m_vout && ready_out) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL sb_pop: output handshake with no expected word (sel %0d)", sel_out);
      end else begin
        b = sbq.pop_front();
        chk("sb_data", 64'(data_out), 64'(b.data));
        chk("sb_sel", 64'(sel_out), 64'(b.sel));
        chk("sb_last", 64'(last_out), 64'(b.last));
      end
    end
    if (g >= 0 && sr) begin
      b.data = data_in[g*DW +: DW];
      b.sel  = LW'(g);
      b.last = last_in[g];
      sbq.push_back(b);
`ifdef RV_STREAM_ARB_PKT_LOCK_EN
      m_lock = !last_in[g];
      m_lidx = g;
      if (last_in[g]) m_ptr = g;
`else
      m_ptr = g;
`endif
      m_vout = 1;
    end else if (ready_out) begin
      m_vout = 0;
    end
  endtask

  // Drive one cycle of stimulus, run the model, then step past the edge.
  task automatic tick(input logic [N-1:0] vin, input logic [N-1:0] lin, input logic rdy,
                      output logic [N-1:0] fired);
    valid_in = vin; last_in = lin; ready_out = rdy;
    #1;
    fired = valid_in & ready_in;
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] fired;
    int           beats;
    int           exp_seq[5];
    vec_t         v;

    for (int i = 0; i < N; i++) data_in[i*DW +: DW] = 32'hA0 + 32'(i);
    reset = 1'b1;
    tick('0, 4'hF, 1'b0, fired);
    tick('0, 4'hF, 1'b0, fired);
    reset = 1'b0;
    chk("rst valid_out", 64'(valid_out), 64'd0);
    chk("rst data_out", 64'(data_out), 64'd0);
    chk("rst sel_out", 64'(sel_out), 64'd0);
    chk("rst last_out", 64'(last_out), 64'd0);

    // All four valid: rotate 0..3 then back to 0.
    for (int s = 0; s < 5; s++) vecs.push_back(mk(4'hF, 1'b1, 1'b1, s % N));
    vecs.push_back(mk(4'h0, 1'b1, 1'b0, 0));
    // Inputs 1 and 3 under a 5-cycle stall: 1 held, then 3 next.
    for (int s = 0; s < 5; s++) vecs.push_back(mk(4'hA, 1'b0, 1'b1, 1));
    vecs.push_back(mk(4'hA, 1'b1, 1'b1, 3));
    vecs.push_back(mk(4'h0, 1'b1, 1'b0, 0));
    // Single streaming input: no bubbles.
    for (int s = 0; s < 4; s++) vecs.push_back(mk(4'h4, 1'b1, 1'b1, 2));
    // Drain and refill in the same cycle.
    vecs.push_back(mk(4'h1, 1'b1, 1'b1, 0));
    vecs.push_back(mk(4'h0, 1'b1, 1'b0, 0));

    for (int r = 0; r < vecs.size(); r++) begin
      v = vecs[r];
      tick(v.vin, v.lin, v.rdy, fired);
      chk($sformatf("vec%0d valid", r), 64'(valid_out), 64'(v.exp_v));
      if (v.exp_v) begin
        chk($sformatf("vec%0d sel", r), 64'(sel_out), 64'(v.exp_sel));
        chk($sformatf("vec%0d data", r), 64'(data_out), 64'(32'hA0 + 32'(v.exp_sel)));
        chk($sformatf("vec%0d last", r), 64'(last_out), 64'(v.lin[v.exp_sel]));
      end
    end

    // Input 1 sends a 3-beat packet while input 2 keeps requesting.
`ifdef RV_STREAM_ARB_PKT_LOCK_EN
    exp_seq = '{1, 1, 1, 2, 2};
`else
    exp_seq = '{1, 2, 1, 2, 1};
`endif
    beats = 3;
    for (int c = 0; c < 5; c++) begin
      tick({1'b0, 1'b1, (beats > 0), 1'b0}, {1'b1, 1'b1, (beats == 1), 1'b1}, 1'b1, fired);
      if (fired[1]) beats--;
      chk($sformatf("pkt%0d valid", c), 64'(valid_out), 64'd1);
      chk($sformatf("pkt%0d sel", c), 64'(sel_out), 64'(exp_seq[c]));
    end
    chk("pkt beats left", 64'(beats), 64'd0);

    // Reset while a word is stalled at the output.
    tick(4'h0, 4'hF, 1'b1, fired);
    tick(4'h8, 4'hF, 1'b0, fired);
    chk("stall valid", 64'(valid_out), 64'd1);
    chk("stall sel", 64'(sel_out), 64'd3);
    tick(4'h8, 4'hF, 1'b0, fired);
    reset = 1'b1;
    tick(4'hA, 4'hF, 1'b0, fired);
    reset = 1'b0;
    chk("midrst valid_out", 64'(valid_out), 64'd0);
    tick(4'hA, 4'hF, 1'b1, fired);
    chk("postrst valid", 64'(valid_out), 64'd1);
    chk("postrst sel", 64'(sel_out), 64'd1);
    tick(4'h0, 4'hF, 1'b1, fired);
    tick(4'h0, 4'hF, 1'b1, fired);
    chk("sb leftover", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
